// File: rtl/ex_ctl.sv
// ex_ctl: registered EX-stage control decode for the minicpu pipeline, plus a
// countdown sequencer for multi-cycle MULT/DIV and the HI/LO interlock.
// Optional feature macro: EX_CTL_DIV_EN. When it is defined, DIV/DIVU are
// sequenced. When it is undefined, DIV/DIVU decode as illegal and md_div is 0.
module ex_ctl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] I2,
  input  logic        i_valid,
  input  logic        stall_in,
  input  logic        WriteLabel,
  output logic [7:0]  ALUsel,
  output logic [5:0]  QCsel,
  output logic        UseImm,
  output logic        illegal,
  output logic        ex_stall,
  output logic        md_busy,
  output logic        md_done,
  output logic        md_div,
  output logic        md_label
);

  // ALU select encodings. Unsigned add/sub share the signed codes.
  localparam logic [7:0] select_alu_add  = 8'h01;
  localparam logic [7:0] select_alu_sub  = 8'h02;
  localparam logic [7:0] select_alu_and  = 8'h03;
  localparam logic [7:0] select_alu_or   = 8'h04;
  localparam logic [7:0] select_alu_xor  = 8'h05;
  localparam logic [7:0] select_alu_nor  = 8'h06;
  localparam logic [7:0] select_alu_slt  = 8'h07;
  localparam logic [7:0] select_alu_sltu = 8'h08;
  localparam logic [7:0] select_alu_sll  = 8'h09;
  localparam logic [7:0] select_alu_srl  = 8'h0A;
  localparam logic [7:0] select_alu_sra  = 8'h0B;
  localparam logic [7:0] select_alu_sllv = 8'h0C;
  localparam logic [7:0] select_alu_srlv = 8'h0D;
  localparam logic [7:0] select_alu_srav = 8'h0E;
  localparam logic [7:0] select_alu_lui  = 8'h0F;

  // Quick-compare select encodings.
  localparam logic [5:0] select_qc_eq  = 6'h01;
  localparam logic [5:0] select_qc_ne  = 6'h02;
  localparam logic [5:0] select_qc_lez = 6'h03;
  localparam logic [5:0] select_qc_gtz = 6'h04;
  localparam logic [5:0] select_qc_ltz = 6'h05;
  localparam logic [5:0] select_qc_gez = 6'h06;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
`ifdef EX_CTL_DIV_EN
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
`else
  localparam int unused_div_cycles = DIV_CYCLES;
`endif

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
`ifdef EX_CTL_DIV_EN
    MD_DIV  = 2'd2,
`endif
    MD_DONE = 2'd3
  } md_state_t;

  logic [5:0]       op_s;
  logic [5:0]       funct_s;
  logic [4:0]       rt_s;
  logic [7:0]       alu_s;
  logic [5:0]       qc_s;
  logic             imm_s;
  logic             ill_s;
  logic             mul_op_s;
  logic             div_op_s;
  logic             hilo_s;
  logic             accept_s;
  logic             start_mul_s;
  logic             start_div_s;
  logic             unused_s;
  md_state_t        state_r;
  md_state_t        state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic             md_label_r;

  assign op_s     = I2[31:26];
  assign funct_s  = I2[5:0];
  assign rt_s     = I2[20:16];
  assign unused_s = ^{I2[25:21], I2[15:6]};

  // Decode the stage-3 instruction into ALU/QC/immediate controls and MD class
  always_comb begin
    alu_s    = 8'h00;
    qc_s     = 6'h00;
    imm_s    = 1'b0;
    ill_s    = 1'b0;
    mul_op_s = 1'b0;
    div_op_s = 1'b0;
    hilo_s   = 1'b0;
    case (op_s)
      6'h00: begin
        case (funct_s)
          6'h00: alu_s = select_alu_sll;
          6'h02: alu_s = select_alu_srl;
          6'h03: alu_s = select_alu_sra;
          6'h04: alu_s = select_alu_sllv;
          6'h06: alu_s = select_alu_srlv;
          6'h07: alu_s = select_alu_srav;
          6'h08, 6'h09: alu_s = 8'h00;  // JR/JALR: no ALU work
          6'h10, 6'h11, 6'h12, 6'h13: hilo_s = 1'b1;
          6'h18, 6'h19: mul_op_s = 1'b1;
`ifdef EX_CTL_DIV_EN
          6'h1A, 6'h1B: div_op_s = 1'b1;
`else
          6'h1A, 6'h1B: ill_s = 1'b1;
`endif
          6'h20, 6'h21: alu_s = select_alu_add;
          6'h22, 6'h23: alu_s = select_alu_sub;
          6'h24: alu_s = select_alu_and;
          6'h25: alu_s = select_alu_or;
          6'h26: alu_s = select_alu_xor;
          6'h27: alu_s = select_alu_nor;
          6'h2A: alu_s = select_alu_slt;
          6'h2B: alu_s = select_alu_sltu;
          default: ill_s = 1'b1;
        endcase
      end
      6'h01: begin
        case (rt_s)
          5'h00, 5'h10: qc_s = select_qc_ltz;
          5'h01, 5'h11: qc_s = select_qc_gez;
          default: ill_s = 1'b1;
        endcase
      end
      6'h02, 6'h03: alu_s = 8'h00;  // J/JAL: no ALU work
      6'h04: qc_s = select_qc_eq;
      6'h05: qc_s = select_qc_ne;
      6'h06: qc_s = select_qc_lez;
      6'h07: qc_s = select_qc_gtz;
      6'h08, 6'h09: begin alu_s = select_alu_add;  imm_s = 1'b1; end
      6'h0A: begin alu_s = select_alu_slt;  imm_s = 1'b1; end
      6'h0B: begin alu_s = select_alu_sltu; imm_s = 1'b1; end
      6'h0C: begin alu_s = select_alu_and;  imm_s = 1'b1; end
      6'h0D: begin alu_s = select_alu_or;   imm_s = 1'b1; end
      6'h0E: begin alu_s = select_alu_xor;  imm_s = 1'b1; end
      6'h0F: begin alu_s = select_alu_lui;  imm_s = 1'b1; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: begin
        alu_s = select_alu_add;
        imm_s = 1'b1;
      end
      default: ill_s = 1'b1;
    endcase
  end

  // Only HI/LO users are held back while the multiplier/divider is busy
  assign ex_stall    = i_valid & md_busy & (mul_op_s | div_op_s | hilo_s);
  assign accept_s    = i_valid & ~ex_stall & ~stall_in;
  assign start_mul_s = accept_s & mul_op_s;
  assign start_div_s = accept_s & div_op_s;

  // Register decoded controls: hold under stall_in, bubble when nothing is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ALUsel  <= 8'h00;
      QCsel   <= 6'h00;
      UseImm  <= 1'b0;
      illegal <= 1'b0;
    end else if (!stall_in) begin
      if (accept_s) begin
        ALUsel  <= alu_s;
        QCsel   <= qc_s;
        UseImm  <= imm_s;
        illegal <= ill_s;
      end else begin
        ALUsel  <= 8'h00;
        QCsel   <= 6'h00;
        UseImm  <= 1'b0;
        illegal <= 1'b0;
      end
    end
  end

  // MD sequencer state and countdown register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= MD_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // MD next state: start from IDLE or DONE, count down while busy, one DONE cycle
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      MD_IDLE, MD_DONE: begin
        if (start_mul_s) begin
          state_nx_s = MD_MUL;
          cnt_nx_s   = MUL_LOAD;
`ifdef EX_CTL_DIV_EN
        end else if (start_div_s) begin
          state_nx_s = MD_DIV;
          cnt_nx_s   = DIV_LOAD;
`endif
        end else begin
          state_nx_s = MD_IDLE;
          cnt_nx_s   = {CNT_W{1'b0}};
        end
      end
`ifdef EX_CTL_DIV_EN
      MD_MUL, MD_DIV: begin
`else
      MD_MUL: begin
`endif
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nx_s = MD_DONE;
        end else begin
          cnt_nx_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nx_s = MD_IDLE;
        cnt_nx_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Latch the result label (and divide flag) when an MD op starts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_label_r <= 1'b0;
    end else if (start_mul_s | start_div_s) begin
      md_label_r <= WriteLabel;
    end
  end

`ifdef EX_CTL_DIV_EN
  logic md_div_r;

  // Remember whether the active/last MD op is a divide
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_div_r <= 1'b0;
    end else if (start_mul_s | start_div_s) begin
      md_div_r <= start_div_s;
    end
  end

  assign md_div  = md_div_r;
  assign md_busy = (state_r == MD_MUL) | (state_r == MD_DIV);
`else
  assign md_div  = 1'b0;
  assign md_busy = (state_r == MD_MUL);
`endif

  assign md_done  = (state_r == MD_DONE);
  assign md_label = md_label_r;

endmodule

// File: tb/tb_ex_ctl.sv
// tb_ex_ctl: directed self-checking bench for ex_ctl (MUL_CYCLES=4, DIV_CYCLES=33).
// Follows EX_CTL_DIV_EN the same way the design does.
module tb_ex_ctl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] I2 = 32'h0;
  logic        i_valid = 1'b0;
  logic        stall_in = 1'b0;
  logic        WriteLabel = 1'b0;
  logic [7:0]  ALUsel;
  logic [5:0]  QCsel;
  logic        UseImm, illegal, ex_stall, md_busy, md_done, md_div, md_label;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [7:0] ALU_ADD = 8'h01;
  localparam logic [7:0] ALU_SUB = 8'h02;
  localparam logic [5:0] QC_EQ   = 6'h01;
  localparam logic [5:0] QC_GEZ  = 6'h06;

  localparam logic [31:0] ADDI   = {6'h08, 5'd0, 5'd1, 16'd5};
  localparam logic [31:0] ADD    = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] SUB    = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22};
  localparam logic [31:0] MULT   = {6'h00, 5'd1, 5'd2, 10'd0, 6'h18};
  localparam logic [31:0] MFLO   = {6'h00, 10'd0, 5'd4, 5'd0, 6'h12};
  localparam logic [31:0] DIV    = {6'h00, 5'd1, 5'd2, 10'd0, 6'h1A};
  localparam logic [31:0] DIVU   = {6'h00, 5'd1, 5'd2, 10'd0, 6'h1B};
  localparam logic [31:0] BGEZAL = {6'h01, 5'd1, 5'd17, 16'd4};
  localparam logic [31:0] BEQ    = {6'h04, 5'd1, 5'd2, 16'd8};
  localparam logic [31:0] LW     = {6'h23, 5'd1, 5'd2, 16'd12};
  localparam logic [31:0] BADOP  = {6'h3F, 26'd0};

  ex_ctl #(.MUL_CYCLES(4), .DIV_CYCLES(33), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .I2(I2), .i_valid(i_valid),
    .stall_in(stall_in), .WriteLabel(WriteLabel),
    .ALUsel(ALUsel), .QCsel(QCsel), .UseImm(UseImm), .illegal(illegal),
    .ex_stall(ex_stall), .md_busy(md_busy), .md_done(md_done),
    .md_div(md_div), .md_label(md_label)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic s, input logic l);
    I2 = ins;
    i_valid = v;
    stall_in = s;
    WriteLabel = l;
    #1;
  endtask

  initial begin
    logic seen;
    logic exp_stall;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    tick;
    check("reset_outputs", {ALUsel, QCsel, UseImm, illegal, md_busy, md_done, md_div, md_label, ex_stall}, 32'h0);
    reset_n = 1'b1;
    tick;

    // ADDI, then a bubble
    drive(ADDI, 1'b1, 1'b0, 1'b0);
    tick;
    check("addi_alusel", ALUsel, ALU_ADD);
    check("addi_useimm", UseImm, 1'b1);
    check("addi_illegal", illegal, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    check("bubble_outputs", {ALUsel, QCsel, UseImm, illegal}, 32'h0);

    // MULT with an unrelated ADD flowing while busy
    drive(MULT, 1'b1, 1'b0, 1'b1);
    check("mult_nostall", ex_stall, 1'b0);
    tick;
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) drive(ADD, 1'b1, 1'b0, 1'b0);
      else        drive(32'h0, 1'b0, 1'b0, 1'b0);
      check($sformatf("mult_busy_c%0d", c), md_busy, (c <= 4));
      check($sformatf("mult_done_c%0d", c), md_done, (c == 5));
      check($sformatf("mult_div_c%0d", c), md_div, 1'b0);
      check($sformatf("mult_label_c%0d", c), md_label, 1'b1);
      if (c == 2) check("add_nostall", ex_stall, 1'b0);
      if (c == 3) check("add_alusel", ALUsel, ALU_ADD);
      tick;
    end

    // MULT then MFLO: stalled while busy, accepted in DONE
    drive(MULT, 1'b1, 1'b0, 1'b0);
    tick;
    for (int c = 1; c <= 5; c++) begin
      drive(MFLO, 1'b1, 1'b0, 1'b0);
      check($sformatf("mflo_stall_c%0d", c), ex_stall, (c <= 4));
      check($sformatf("mflo_done_c%0d", c), md_done, (c == 5));
      tick;
    end
    check("mflo_accepted", {md_busy, illegal, ALUsel}, 32'h0);

    // MULT then a divide presented while busy
    drive(MULT, 1'b1, 1'b0, 1'b0);
    tick;
    for (int c = 1; c <= 5; c++) begin
`ifdef EX_CTL_DIV_EN
      drive(DIV, 1'b1, 1'b0, 1'b1);
      exp_stall = (c <= 4);
`else
      drive(DIVU, 1'b1, 1'b0, 1'b1);
      exp_stall = 1'b0;
`endif
      check($sformatf("div_stall_c%0d", c), ex_stall, exp_stall);
      tick;
    end
`ifdef EX_CTL_DIV_EN
    for (int d = 1; d <= 34; d++) begin
      drive(32'h0, 1'b0, 1'b0, 1'b0);
      check($sformatf("div_busy_d%0d", d), md_busy, (d <= 33));
      check($sformatf("div_done_d%0d", d), md_done, (d == 34));
      check($sformatf("div_flag_d%0d", d), md_div, 1'b1);
      tick;
    end
    check("div_label", md_label, 1'b1);
`else
    check("divu_illegal", illegal, 1'b1);
    check("divu_busy", md_busy, 1'b0);
    check("divu_mddiv", md_div, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick;
`endif

    // Asynchronous reset in the middle of an MD op
`ifdef EX_CTL_DIV_EN
    drive(DIV, 1'b1, 1'b0, 1'b1);
`else
    drive(MULT, 1'b1, 1'b0, 1'b1);
`endif
    tick;
    drive(ADDI, 1'b1, 1'b0, 1'b0);
    tick;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    check("prerst_busy", md_busy, 1'b1);
    check("prerst_alusel", ALUsel, ALU_ADD);
    check("prerst_label", md_label, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midop_reset_outputs", {ALUsel, QCsel, UseImm, illegal, md_busy, md_done, md_div, md_label, ex_stall}, 32'h0);
    tick;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick;
      seen = seen | md_done | md_busy;
    end
    check("no_done_after_reset", seen, 1'b0);

    // Branch compare selects, loads, reserved opcode
    drive(BGEZAL, 1'b1, 1'b0, 1'b0);
    tick;
    check("bgezal_qcsel", QCsel, QC_GEZ);
    check("bgezal_illegal", illegal, 1'b0);
    drive(BEQ, 1'b1, 1'b0, 1'b0);
    tick;
    check("beq_qcsel", QCsel, QC_EQ);
    drive(LW, 1'b1, 1'b0, 1'b0);
    tick;
    check("lw_ctl", {ALUsel, UseImm, QCsel}, {17'h0, ALU_ADD, 1'b1, 6'h00});
    drive(BADOP, 1'b1, 1'b0, 1'b0);
    tick;
    check("badop_illegal", {illegal, ALUsel}, {23'h0, 1'b1, 8'h00});

    // stall_in freezes registered outputs
    drive(ADDI, 1'b1, 1'b0, 1'b0);
    tick;
    for (int s = 1; s <= 3; s++) begin
      drive(SUB, 1'b1, 1'b1, 1'b0);
      check($sformatf("stallin_nostall_s%0d", s), ex_stall, 1'b0);
      tick;
      check($sformatf("stallin_hold_s%0d", s), {ALUsel, UseImm, illegal}, {22'h0, ALU_ADD, 1'b1, 1'b0});
    end
    drive(SUB, 1'b1, 1'b0, 1'b0);
    tick;
    check("sub_after_stall", {ALUsel, UseImm}, {23'h0, ALU_SUB, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
